// File: rtl/accel_cmd_arbiter.sv
// accel_cmd_arbiter: round-robin datamover command arbiter with in-order status return and per-channel irq registers
module accel_cmd_arbiter #(
    parameter int C_NUM_CHANNELS     = 4,
    parameter int C_CMD_WIDTH        = 72,
    parameter int C_STS_WIDTH        = 8,
    parameter int C_MAX_OUTSTANDING  = 8,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [C_NUM_CHANNELS*C_CMD_WIDTH-1:0]  s_cmd_tdata,
    input  logic [C_NUM_CHANNELS-1:0]              s_cmd_tvalid,
    output logic [C_NUM_CHANNELS-1:0]              s_cmd_tready,
    output logic [C_CMD_WIDTH-1:0]                 m_cmd_tdata,
    output logic                                   m_cmd_tvalid,
    input  logic                                   m_cmd_tready,
    input  logic [C_STS_WIDTH-1:0]                 s_sts_tdata,
    input  logic                                   s_sts_tvalid,
    output logic                                   s_sts_tready,
    output logic [C_STS_WIDTH-1:0]                 m_sts_tdata,
    output logic [C_NUM_CHANNELS-1:0]              m_sts_tvalid,
    input  logic [C_NUM_CHANNELS-1:0]              m_sts_tready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          set_addr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          set_data,
    input  logic                                   set_stb,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          get_addr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          get_data,
    output logic                                   irq
);
    localparam int N  = C_NUM_CHANNELS;
    localparam int GW = $clog2(N);
    localparam int PW = $clog2(C_MAX_OUTSTANDING);
    localparam int DW = C_S_AXI_DATA_WIDTH;

    typedef enum logic {IDLE, SEND} state_t;

    state_t                 state;
    logic [GW-1:0]          grant, last_grant, pick, head;
    logic [C_CMD_WIDTH-1:0] cmd_data;
    logic [GW-1:0]          fifo [C_MAX_OUTSTANDING];
    logic [PW-1:0]          wr_ptr, rd_ptr;
    logic [PW:0]            count;
    logic [N-1:0]           pending, mask;
    logic [DW-1:0]          err_count;
    logic                   full, empty, take, push, pop, sts_err;
    logic                   wr_pend, wr_mask, wr_err;
    logic                   unused_bits;

    // lowest valid channel above last_grant wins, otherwise wrap to lowest valid overall
    always_comb begin
        pick = '0;
        for (int j = N - 1; j >= 0; j--)
            if (s_cmd_tvalid[j]) pick = GW'(j);
        for (int j = N - 1; j >= 0; j--)
            if (s_cmd_tvalid[j] && GW'(j) > last_grant) pick = GW'(j);
    end

    assign full         = count == (PW+1)'(C_MAX_OUTSTANDING);
    assign empty        = count == '0;
    assign take         = !rst && state == IDLE && |s_cmd_tvalid && !full;
    assign push         = state == SEND && m_cmd_tready;
    assign head         = fifo[rd_ptr];
    assign s_sts_tready = !empty && m_sts_tready[head];
    assign pop          = s_sts_tvalid && s_sts_tready;
    assign s_cmd_tready = take ? (N'(1) << pick) : '0;
    assign m_cmd_tvalid = state == SEND;
    assign m_cmd_tdata  = cmd_data;
    assign m_sts_tvalid = (!empty && s_sts_tvalid) ? (N'(1) << head) : '0;
    assign m_sts_tdata  = s_sts_tdata;
    assign sts_err      = !s_sts_tdata[7] || |s_sts_tdata[6:4];
    assign wr_pend      = set_stb && set_addr[3:2] == 2'd0;
    assign wr_mask      = set_stb && set_addr[3:2] == 2'd1;
    assign wr_err       = set_stb && set_addr[3:2] == 2'd3;
    assign irq          = |(pending & mask);
    assign unused_bits  = ^{set_addr, get_addr, set_data};

    assign get_data = get_addr[3:2] == 2'd0 ? DW'(pending) :
                      get_addr[3:2] == 2'd1 ? DW'(mask)    :
                      get_addr[3:2] == 2'd2 ? DW'(count)   : err_count;

    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= grant;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= GW'(N - 1);
            cmd_data   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            pending    <= '0;
            mask       <= '0;
            err_count  <= '0;
        end else begin
            if (take) begin
                state    <= SEND;
                grant    <= pick;
                cmd_data <= s_cmd_tdata[pick*C_CMD_WIDTH +: C_CMD_WIDTH];
            end
            if (push) begin
                state      <= IDLE;
                last_grant <= grant;
                wr_ptr     <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count     <= count + (PW+1)'(push) - (PW+1)'(pop);
            // a status arriving in the same cycle as its W1C keeps the bit set
            pending   <= (pending & ~(wr_pend ? set_data[N-1:0] : '0)) | (pop ? (N'(1) << head) : '0);
            mask      <= wr_mask ? set_data[N-1:0] : mask;
            err_count <= wr_err ? '0 : (pop && sts_err && err_count != '1) ? err_count + 1'b1 : err_count;
        end
    end
endmodule

// File: tb/tb_accel_cmd_arbiter.sv
// tb_accel_cmd_arbiter: vector tables, directed corner sequences and a command/status scoreboard
module tb_accel_cmd_arbiter;
    localparam int N  = 4;
    localparam int CW = 72;
    localparam int SW = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N*CW-1:0] s_cmd_tdata = '0;
    logic [N-1:0]    s_cmd_tvalid = '0;
    logic [N-1:0]    s_cmd_tready;
    logic [CW-1:0]   m_cmd_tdata;
    logic            m_cmd_tvalid;
    logic            m_cmd_tready = 1'b0;
    logic [SW-1:0]   s_sts_tdata = '0;
    logic            s_sts_tvalid = 1'b0;
    logic            s_sts_tready;
    logic [SW-1:0]   m_sts_tdata;
    logic [N-1:0]    m_sts_tvalid;
    logic [N-1:0]    m_sts_tready = '1;
    logic [31:0]     set_addr = '0;
    logic [31:0]     set_data = '0;
    logic            set_stb = 1'b0;
    logic [31:0]     get_addr = '0;
    logic [31:0]     get_data;
    logic            irq;

    int tests = 0;
    int fails = 0;

    typedef struct { int ch; logic [CW-1:0] d; } cmd_t;
    typedef struct { logic [N-1:0] valid; logic [N-1:0] exp_ready; } rr_vec_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; logic [31:0] exp; } reg_vec_t;

    cmd_t     cmd_q[$];
    int       sts_q[$];
    cmd_t     mon_c;
    int       mon_ch;
    rr_vec_t  rr_tab[7];
    reg_vec_t reg_tab[11];
    logic [N-1:0] got_ready[5];
    logic [N-1:0] exp_order[5];

    accel_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .s_cmd_tdata(s_cmd_tdata), .s_cmd_tvalid(s_cmd_tvalid), .s_cmd_tready(s_cmd_tready),
        .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
        .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
        .m_sts_tdata(m_sts_tdata), .m_sts_tvalid(m_sts_tvalid), .m_sts_tready(m_sts_tready),
        .set_addr(set_addr), .set_data(set_data), .set_stb(set_stb),
        .get_addr(get_addr), .get_data(get_data), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
        get_addr = a;
        #1;
        check(name, get_data, exp);
    endtask

    task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
        set_addr = a;
        set_data = d;
        set_stb  = 1'b1;
        @(negedge clk);
        set_stb  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_cmd_tvalid = '0;
        s_sts_tvalid = 1'b0;
        set_stb = 1'b0;
        cmd_q.delete();
        sts_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic issue(input int ch, input logic [CW-1:0] d);
        bit ok = 0;
        s_cmd_tdata[ch*CW +: CW] = d;
        s_cmd_tvalid[ch] = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = s_cmd_tready[ch];
            @(negedge clk);
        end
        s_cmd_tvalid[ch] = 1'b0;
        if (!ok) check("issue_timeout", 0, 1);
    endtask

    task automatic ret_sts(input logic [SW-1:0] v);
        bit ok = 0;
        s_sts_tdata  = v;
        s_sts_tvalid = 1'b1;
        for (int k = 0; k < 20 && !ok; k++) begin
            #1;
            ok = s_sts_tready;
            @(negedge clk);
        end
        s_sts_tvalid = 1'b0;
        if (!ok) check("sts_timeout", 0, 1);
    endtask

    // scoreboard: grants queue the command, datamover accepts check it and queue its owner
    always begin
        @(negedge clk);
        #4;
        if (!rst) begin
            for (int i = 0; i < N; i++)
                if (s_cmd_tvalid[i] && s_cmd_tready[i]) cmd_q.push_back('{i, s_cmd_tdata[i*CW +: CW]});
            if (m_cmd_tvalid && m_cmd_tready) begin
                if (cmd_q.size() == 0) check("sb_cmd_extra", 1, 0);
                else begin
                    mon_c = cmd_q.pop_front();
                    check("sb_cmd_data", m_cmd_tdata, mon_c.d);
                    sts_q.push_back(mon_c.ch);
                end
            end
            if (s_sts_tvalid && s_sts_tready) begin
                if (sts_q.size() == 0) check("sb_sts_extra", 1, 0);
                else begin
                    mon_ch = sts_q.pop_front();
                    check("sb_sts_route", m_sts_tvalid, 4'b0001 << mon_ch);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_tab[0] = '{4'b1010, 4'b0010};
        rr_tab[1] = '{4'b1001, 4'b1000};
        rr_tab[2] = '{4'b0110, 4'b0010};
        rr_tab[3] = '{4'b0001, 4'b0001};
        rr_tab[4] = '{4'b0101, 4'b0100};
        rr_tab[5] = '{4'b0100, 4'b0100};
        rr_tab[6] = '{4'b1111, 4'b1000};
        reg_tab[0]  = '{1'b1, 32'h4, 32'hFFFF_FFFF, 32'h0};
        reg_tab[1]  = '{1'b0, 32'h4, 32'h0, 32'h0000_000F};
        reg_tab[2]  = '{1'b0, 32'h0, 32'h0, 32'h0};
        reg_tab[3]  = '{1'b0, 32'h8, 32'h0, 32'h0};
        reg_tab[4]  = '{1'b0, 32'hC, 32'h0, 32'h0};
        reg_tab[5]  = '{1'b1, 32'h4, 32'h5, 32'h0};
        reg_tab[6]  = '{1'b0, 32'h4, 32'h0, 32'h5};
        reg_tab[7]  = '{1'b1, 32'h8, 32'hFF, 32'h0};
        reg_tab[8]  = '{1'b0, 32'h8, 32'h0, 32'h0};
        reg_tab[9]  = '{1'b1, 32'h4, 32'h0, 32'h0};
        reg_tab[10] = '{1'b0, 32'h4, 32'h0, 32'h0};
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // reset state, with requests already pending
        s_cmd_tvalid = '1;
        #1;
        check("rst_s_cmd_tready", s_cmd_tready, 0);
        check("rst_m_cmd_tvalid", m_cmd_tvalid, 0);
        check("rst_m_cmd_tdata", m_cmd_tdata, 0);
        check("rst_irq", irq, 0);
        rd_check("rst_outstanding", 32'h8, 0);
        s_cmd_tvalid = '0;
        do_reset();
        s_sts_tvalid = 1'b1;
        #1;
        check("spurious_sts_tready", s_sts_tready, 0);
        check("spurious_sts_tvalid", m_sts_tvalid, 0);
        s_sts_tvalid = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if (reg_tab[i].wr) reg_write(reg_tab[i].addr, reg_tab[i].data);
            else rd_check($sformatf("reg_vec%0d", i), reg_tab[i].addr, reg_tab[i].exp);
        end

        // single channel command, status and irq
        do_reset();
        s_cmd_tdata[CW-1:0] = 72'hA5;
        s_cmd_tvalid = 4'b0001;
        #1;
        check("t1_grant", s_cmd_tready, 4'b0001);
        check("t1_no_tvalid_yet", m_cmd_tvalid, 0);
        @(negedge clk);
        s_cmd_tvalid = '0;
        #1;
        check("t1_tvalid", m_cmd_tvalid, 1);
        check("t1_tdata", m_cmd_tdata, 72'hA5);
        m_cmd_tready = 1'b1;
        @(negedge clk);
        m_cmd_tready = 1'b0;
        rd_check("t1_outstanding", 32'h8, 1);
        s_sts_tdata = 8'h80;
        s_sts_tvalid = 1'b1;
        #1;
        check("t1_sts_tvalid", m_sts_tvalid, 4'b0001);
        check("t1_sts_tdata", m_sts_tdata, 8'h80);
        @(negedge clk);
        s_sts_tvalid = 1'b0;
        rd_check("t1_pending", 32'h0, 1);
        check("t1_irq_masked", irq, 0);
        reg_write(32'h4, 32'h1);
        #1;
        check("t1_irq_unmasked", irq, 1);
        reg_write(32'h0, 32'h1);
        #1;
        check("t1_irq_cleared", irq, 0);
        rd_check("t1_pending_cleared", 32'h0, 0);

        // all channels requesting continuously
        do_reset();
        m_cmd_tready = 1'b1;
        for (int i = 0; i < N; i++) s_cmd_tdata[i*CW +: CW] = 72'h100 + 72'(i);
        s_cmd_tvalid = '1;
        begin
            int idx = 0;
            for (int c = 0; c < 30 && idx < 5; c++) begin
                #1;
                if (|s_cmd_tready) begin
                    got_ready[idx] = s_cmd_tready;
                    idx++;
                end
                @(negedge clk);
            end
            s_cmd_tvalid = '0;
            if (idx < 5) check("t2_grant_timeout", idx, 5);
            else for (int k = 0; k < 5; k++) check($sformatf("t2_grant%0d", k), got_ready[k], exp_order[k]);
        end
        @(negedge clk);
        @(negedge clk);
        s_sts_tdata = 8'h80;
        s_sts_tvalid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("t2_sts%0d", k), m_sts_tvalid, exp_order[k]);
            @(negedge clk);
        end
        s_sts_tvalid = 1'b0;

        // round-robin vector table continuing from last grant 0
        for (int i = 0; i < 7; i++) begin
            s_cmd_tdata = {N{72'h5500 + 72'(i)}};
            s_cmd_tvalid = rr_tab[i].valid;
            #1;
            check($sformatf("rr_vec%0d", i), s_cmd_tready, rr_tab[i].exp_ready);
            @(negedge clk);
            s_cmd_tvalid = '0;
            @(negedge clk);
        end
        s_sts_tvalid = 1'b1;
        for (int k = 0; k < 7; k++) @(negedge clk);
        s_sts_tvalid = 1'b0;
        rd_check("rr_drained", 32'h8, 0);

        // FIFO full back-pressure, then simultaneous push and pop
        do_reset();
        m_cmd_tready = 1'b1;
        for (int k = 0; k < 8; k++) issue(k % N, 72'h3000 + 72'(k));
        @(negedge clk);
        rd_check("t3_outstanding_full", 32'h8, 8);
        s_cmd_tdata[CW-1:0] = 72'h3009;
        s_cmd_tvalid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t3_full_no_grant", s_cmd_tready, 0);
            @(negedge clk);
        end
        s_sts_tdata = 8'h80;
        s_sts_tvalid = 1'b1;
        #1;
        check("t3_pop_cycle_no_grant", s_cmd_tready, 0);
        @(negedge clk);
        s_sts_tvalid = 1'b0;
        #1;
        check("t3_grant_after_pop", s_cmd_tready, 4'b0001);
        @(negedge clk);
        s_cmd_tvalid = '0;
        @(negedge clk);
        rd_check("t3_outstanding_refill", 32'h8, 8);
        ret_sts(8'h80);
        m_cmd_tready = 1'b0;
        s_cmd_tdata[CW +: CW] = 72'h3010;
        s_cmd_tvalid = 4'b0010;
        @(negedge clk);
        s_cmd_tvalid = '0;
        m_cmd_tready = 1'b1;
        s_sts_tvalid = 1'b1;
        @(negedge clk);
        s_sts_tvalid = 1'b0;
        rd_check("t3_push_pop_same", 32'h8, 7);

        // datamover stall in SEND
        do_reset();
        m_cmd_tready = 1'b0;
        issue(2, 72'hBEEF02);
        s_cmd_tvalid = '1;
        for (int k = 0; k < 5; k++) begin
            s_cmd_tdata[2*CW +: CW] = 72'h7700 + 72'(k);
            #1;
            check("t4_tvalid_held", m_cmd_tvalid, 1);
            check("t4_tdata_held", m_cmd_tdata, 72'hBEEF02);
            check("t4_no_grant", s_cmd_tready, 0);
            @(negedge clk);
        end
        s_cmd_tvalid = '0;
        m_cmd_tready = 1'b1;
        @(negedge clk);
        rd_check("t4_pushed", 32'h8, 1);

        // error counting and W1C collision
        do_reset();
        m_cmd_tready = 1'b1;
        issue(0, 72'h50);
        issue(0, 72'h51);
        issue(1, 72'h52);
        issue(1, 72'h53);
        @(negedge clk);
        ret_sts(8'h40);
        rd_check("t5_err1", 32'hC, 1);
        ret_sts(8'h00);
        rd_check("t5_err2", 32'hC, 2);
        reg_write(32'hC, 32'h1234);
        rd_check("t5_err_clear", 32'hC, 0);
        ret_sts(8'h80);
        rd_check("t5_pending_ch01", 32'h0, 3);
        s_sts_tdata = 8'h80;
        s_sts_tvalid = 1'b1;
        reg_write(32'h0, 32'h2);
        s_sts_tvalid = 1'b0;
        rd_check("t5_set_beats_w1c", 32'h0, 3);
        rd_check("t5_no_err_on_okay", 32'hC, 0);
        reg_write(32'h0, 32'h2);
        rd_check("t5_w1c_alone", 32'h0, 1);

        // asynchronous reset mid-transfer
        do_reset();
        m_cmd_tready = 1'b1;
        issue(0, 72'h60);
        issue(1, 72'h61);
        issue(2, 72'h62);
        @(negedge clk);
        m_cmd_tready = 1'b0;
        issue(3, 72'h63);
        s_sts_tdata = 8'h80;
        s_sts_tvalid = 1'b1;
        rd_check("t6_outstanding_before", 32'h8, 3);
        check("t6_tvalid_before", m_cmd_tvalid, 1);
        check("t6_sts_tready_before", s_sts_tready, 1);
        #1;
        rst = 1'b1;
        #1;
        check("t6_tvalid_async", m_cmd_tvalid, 0);
        check("t6_sts_tready_async", s_sts_tready, 0);
        check("t6_outstanding_async", get_data, 0);
        do_reset();
        s_cmd_tvalid = '1;
        #1;
        check("t6_first_grant", s_cmd_tready, 4'b0001);
        @(negedge clk);
        s_cmd_tvalid = '0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
